// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, shift funct codes,
// skid-buffer state encoding and the operand entry layout.
package cpu_pkg;

  localparam int CPU_DATA_W  = 32;
  localparam int CPU_SHAMT_W = 5;
  localparam int CPU_REG_W   = 5;
  localparam int CPU_FUNCT_W = 6;
  localparam int CPU_CNT_W   = 16;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [CPU_DATA_W-1:0]  data;
    logic [CPU_DATA_W-1:0]  amount;
    logic [CPU_FUNCT_W-1:0] signal;
    logic                   is_shift;
    logic [CPU_REG_W-1:0]   rd_idx;
    logic                   reg_write;
  } entry_t;

endpackage

// File: rtl/shift_operand_sel.sv
// Shift operand select: picks shamt or full rs as the amount,
// with optional rs/rt override from a forwarding port.
module shift_operand_sel
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int SHAMT_W = CPU_SHAMT_W,
`ifdef SHIFT_FWD_EN
  parameter int REG_W   = CPU_REG_W,
`endif
  parameter int FUNCT_W = CPU_FUNCT_W
) (
  output logic [DATA_W-1:0]  o_amount,
  output logic               o_is_shift,
  output logic [DATA_W-1:0]  o_data,
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [DATA_W-1:0]  i_rs_data,
  input  logic [DATA_W-1:0]  i_rt_data
`ifdef SHIFT_FWD_EN
  ,
  input  logic [REG_W-1:0]   i_rs_idx,
  input  logic [REG_W-1:0]   i_rt_idx,
  input  logic               i_fwd_valid,
  input  logic [REG_W-1:0]   i_fwd_idx,
  input  logic [DATA_W-1:0]  i_fwd_data
`endif
);

  logic [DATA_W-1:0] w_rs;
  logic [DATA_W-1:0] w_rt;

`ifdef SHIFT_FWD_EN
  logic w_fwd_ok;
  assign w_fwd_ok = i_fwd_valid && (i_fwd_idx != '0);
  assign w_rs = (w_fwd_ok && i_fwd_idx == i_rs_idx) ? i_fwd_data : i_rs_data;
  assign w_rt = (w_fwd_ok && i_fwd_idx == i_rt_idx) ? i_fwd_data : i_rt_data;
`else
  assign w_rs = i_rs_data;
  assign w_rt = i_rt_data;
`endif

  assign o_data = w_rt;

  // SLLV keeps the full rs value; the shifter zeroes amounts >= width
  always_comb begin
    o_amount   = '0;
    o_is_shift = 1'b0;
    unique case (1'b1)
      (i_funct == FUNCT_SLL): begin
        o_amount   = {{(DATA_W-SHAMT_W){1'b0}}, i_shamt};
        o_is_shift = 1'b1;
      end
      (i_funct == FUNCT_SLLV): begin
        o_amount   = w_rs;
        o_is_shift = 1'b1;
      end
      default: begin
        o_amount   = '0;
        o_is_shift = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_operand_stage.sv
// ID->EX shift operand stage with 2-entry skid buffer.
// Define SHIFT_FWD_EN to add the fwd_valid/fwd_idx/fwd_data bypass.
module shift_operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int SHAMT_W = CPU_SHAMT_W,
  parameter int REG_W   = CPU_REG_W,
  parameter int FUNCT_W = CPU_FUNCT_W,
  parameter int CNT_W   = CPU_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [DATA_W-1:0]  in_rs_data,
  input  logic [DATA_W-1:0]  in_rt_data,
  input  logic [REG_W-1:0]   in_rs_idx,
  input  logic [REG_W-1:0]   in_rt_idx,
  input  logic [REG_W-1:0]   in_rd_idx,
  input  logic               in_reg_write,
`ifdef SHIFT_FWD_EN
  input  logic               fwd_valid,
  input  logic [REG_W-1:0]   fwd_idx,
  input  logic [DATA_W-1:0]  fwd_data,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  sh_data,
  output logic [DATA_W-1:0]  sh_amount,
  output logic [FUNCT_W-1:0] sh_signal,
  output logic               sh_is_shift,
  output logic [REG_W-1:0]   out_rd_idx,
  output logic               out_reg_write,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic [1:0]        r_state;
  entry_t            r_main;
  entry_t            r_skid;
  logic [CNT_W-1:0]  r_stall;

  logic [DATA_W-1:0] w_amount;
  logic [DATA_W-1:0] w_data;
  logic              w_is_shift;
  logic              w_accept;
  logic              w_consume;
  entry_t            w_new;

  shift_operand_sel #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W),
`ifdef SHIFT_FWD_EN
    .REG_W   (REG_W),
`endif
    .FUNCT_W (FUNCT_W)
  ) u_sel (
    .o_amount    (w_amount),
    .o_is_shift  (w_is_shift),
    .o_data      (w_data),
    .i_funct     (in_funct),
    .i_shamt     (in_shamt),
    .i_rs_data   (in_rs_data),
    .i_rt_data   (in_rt_data)
`ifdef SHIFT_FWD_EN
    ,
    .i_rs_idx    (in_rs_idx),
    .i_rt_idx    (in_rt_idx),
    .i_fwd_valid (fwd_valid),
    .i_fwd_idx   (fwd_idx),
    .i_fwd_data  (fwd_data)
`endif
  );

`ifndef SHIFT_FWD_EN
  logic w_unused_idx;
  assign w_unused_idx = ^{in_rs_idx, in_rt_idx};
`endif

  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  assign w_new = '{
    data:      w_data,
    amount:    w_amount,
    signal:    in_funct,
    is_shift:  w_is_shift,
    rd_idx:    in_rd_idx,
    reg_write: in_reg_write
  };

  // flush clears entries but the stall counter survives it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_stall <= '0;
    end else begin
      if (out_valid && !out_ready && r_stall != '1)
        r_stall <= r_stall + 1'b1;
      if (flush) begin
        r_state <= ST_EMPTY;
        r_main  <= '0;
        r_skid  <= '0;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_accept) begin
              r_main  <= w_new;
              r_state <= ST_ONE;
            end
          end
          ST_ONE: begin
            if (w_accept && !w_consume) begin
              r_skid  <= w_new;
              r_state <= ST_TWO;
            end else if (w_accept) begin
              r_main  <= w_new;
            end else if (w_consume) begin
              r_state <= ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (w_consume) begin
              r_main  <= r_skid;
              r_state <= ST_ONE;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
      end
    end
  end

  assign sh_data       = r_main.data;
  assign sh_amount     = r_main.amount;
  assign sh_signal     = r_main.signal;
  assign sh_is_shift   = r_main.is_shift;
  assign out_rd_idx    = r_main.rd_idx;
  assign out_reg_write = r_main.reg_write;
  assign stall_cnt     = r_stall;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Scoreboard bench for shift_operand_stage: directed ops,
// backpressure, flush and mid-stream reset.
module tb_shift_operand_stage;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] amount;
    logic [5:0]  signal;
    logic        is_shift;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [4:0]  in_rs_idx;
  logic [4:0]  in_rt_idx;
  logic [4:0]  in_rd_idx;
  logic        in_reg_write;
`ifdef SHIFT_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sh_data;
  logic [31:0] sh_amount;
  logic [5:0]  sh_signal;
  logic        sh_is_shift;
  logic [4:0]  out_rd_idx;
  logic        out_reg_write;
  logic [15:0] stall_cnt;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  shift_operand_stage dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_funct      (in_funct),
    .in_shamt      (in_shamt),
    .in_rs_data    (in_rs_data),
    .in_rt_data    (in_rt_data),
    .in_rs_idx     (in_rs_idx),
    .in_rt_idx     (in_rt_idx),
    .in_rd_idx     (in_rd_idx),
    .in_reg_write  (in_reg_write),
`ifdef SHIFT_FWD_EN
    .fwd_valid     (fwd_valid),
    .fwd_idx       (fwd_idx),
    .fwd_data      (fwd_data),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .sh_data       (sh_data),
    .sh_amount     (sh_amount),
    .sh_signal     (sh_signal),
    .sh_is_shift   (sh_is_shift),
    .out_rd_idx    (out_rd_idx),
    .out_reg_write (out_reg_write),
    .stall_cnt     (stall_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [4:0] sa,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] rsi, input logic [4:0] rti,
                       input logic [4:0] rd, input logic rw,
                       input logic [31:0] e_amt, input logic e_sh,
                       input logic [31:0] e_data);
    int k;
    in_funct = f; in_shamt = sa;
    in_rs_data = rs; in_rt_data = rt;
    in_rs_idx = rsi; in_rt_idx = rti;
    in_rd_idx = rd; in_reg_write = rw;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: got in_ready=0 want 1");
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{data: e_data, amount: e_amt, signal: f,
                   is_shift: e_sh, rd: rd, rw: rw});
    tick();
    in_valid = 1'b0;
  endtask

  // monitor: consume happens at the next rising edge
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (reset && out_valid && out_ready) begin
      a = '{data: sh_data, amount: sh_amount, signal: sh_signal,
            is_shift: sh_is_shift, rd: out_rd_idx, rw: out_reg_write};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got data=%h amt=%h want none",
                 a.data, a.amount);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          n_err++;
          $display({"FAIL out_entry: got d=%h a=%h s=%h sh=%b rd=%0d rw=%b",
                    " want d=%h a=%h s=%h sh=%b rd=%0d rw=%b"},
                   a.data, a.amount, a.signal, a.is_shift, a.rd, a.rw,
                   e.data, e.amount, e.signal, e.is_shift, e.rd, e.rw);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = '0; in_shamt = '0; in_rs_data = '0; in_rt_data = '0;
    in_rs_idx = '0; in_rt_idx = '0; in_rd_idx = '0; in_reg_write = 1'b0;
`ifdef SHIFT_FWD_EN
    fwd_valid = 1'b0; fwd_idx = '0; fwd_data = '0;
`endif
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_sh_data", sh_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // directed ops, streaming
    out_ready = 1'b1;
    issue(6'h00, 5'd4, 32'h1234, 32'hF0, 5'd1, 5'd2, 5'd3, 1'b1,
          32'd4, 1'b1, 32'hF0);
    chk("lat1_valid", {31'd0, out_valid}, 32'd1);
    issue(6'h04, 5'd9, 32'd40, 32'hDEAD_BEEF, 5'd4, 5'd6, 5'd7, 1'b1,
          32'd40, 1'b1, 32'hDEAD_BEEF);
    issue(6'h20, 5'd7, 32'd9, 32'h55, 5'd1, 5'd2, 5'd8, 1'b1,
          32'd0, 1'b0, 32'h55);
    issue(6'h00, 5'd31, 32'hAAAA, 32'h1, 5'd1, 5'd2, 5'd31, 1'b0,
          32'd31, 1'b1, 32'h1);
    issue(6'h04, 5'd0, 32'hFFFF_FFFF, 32'h8000_0001, 5'd9, 5'd10, 5'd5,
          1'b1, 32'hFFFF_FFFF, 1'b1, 32'h8000_0001);
    repeat (3) tick();
    chk("drain1_valid", {31'd0, out_valid}, 32'd0);

    // backpressure: A then B fill both entries
    out_ready = 1'b0;
    issue(6'h00, 5'd1, 32'h0, 32'hA, 5'd0, 5'd0, 5'd10, 1'b1,
          32'd1, 1'b1, 32'hA);
    issue(6'h04, 5'd0, 32'd2, 32'hB, 5'd0, 5'd0, 5'd11, 1'b1,
          32'd2, 1'b1, 32'hB);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk("bp_stall", {16'd0, stall_cnt}, 32'd3);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("bp_stall_hold", {16'd0, stall_cnt}, 32'd3);
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready2", {31'd0, in_ready}, 32'd1);

    // flush in TWO with an incoming op
    out_ready = 1'b0;
    issue(6'h00, 5'd3, 32'h0, 32'hC, 5'd0, 5'd0, 5'd12, 1'b1,
          32'd3, 1'b1, 32'hC);
    issue(6'h00, 5'd5, 32'h0, 32'hD, 5'd0, 5'd0, 5'd13, 1'b1,
          32'd5, 1'b1, 32'hD);
    in_funct = 6'h04; in_rs_data = 32'd6; in_rt_data = 32'hE;
    in_rd_idx = 5'd14; in_reg_write = 1'b1;
    in_valid = 1'b1;
    flush = 1'b1;
    chk("fl_in_ready_pre", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_sh_data", sh_data, 32'd0);
    chk("fl_sh_amount", sh_amount, 32'd0);
    chk("fl_rd", {27'd0, out_rd_idx}, 32'd0);
    chk("fl_stall", {16'd0, stall_cnt}, 32'd5);
    tick();
    tick();
    chk("fl_dropped", {31'd0, out_valid}, 32'd0);

    // async reset while in TWO
    issue(6'h00, 5'd2, 32'h0, 32'h11, 5'd0, 5'd0, 5'd15, 1'b1,
          32'd2, 1'b1, 32'h11);
    issue(6'h00, 5'd6, 32'h0, 32'h22, 5'd0, 5'd0, 5'd16, 1'b1,
          32'd6, 1'b1, 32'h22);
    chk("pre_rst_stall", {16'd0, stall_cnt}, 32'd6);
    #3;
    reset = 1'b0;
    #1;
    sb.delete();
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    issue(6'h00, 5'd8, 32'h0, 32'h33, 5'd0, 5'd0, 5'd17, 1'b1,
          32'd8, 1'b1, 32'h33);
    chk("mrst_lat1", {31'd0, out_valid}, 32'd1);

`ifdef SHIFT_FWD_EN
    fwd_valid = 1'b1; fwd_idx = 5'd5; fwd_data = 32'h1;
    issue(6'h00, 5'd1, 32'h0, 32'hABCD, 5'd2, 5'd5, 5'd18, 1'b1,
          32'd1, 1'b1, 32'h1);
    fwd_idx = 5'd3; fwd_data = 32'd7;
    issue(6'h04, 5'd0, 32'd40, 32'h99, 5'd3, 5'd4, 5'd19, 1'b1,
          32'd7, 1'b1, 32'h99);
    fwd_idx = 5'd0; fwd_data = 32'h1;
    issue(6'h00, 5'd2, 32'h0, 32'h77, 5'd0, 5'd0, 5'd20, 1'b1,
          32'd2, 1'b1, 32'h77);
    fwd_valid = 1'b0;
`endif

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      tick();
    end
    chk("final_sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
